// File: rtl/bcpu_pkg.sv
// Shared BCPU16 types: thread and register indices and register file address forming.
package bcpu_pkg;

    localparam int THREAD_BITS   = 2;
    localparam int REG_BITS      = 3;
    localparam int REG_ADDR_BITS = THREAD_BITS + REG_BITS;

    typedef logic [THREAD_BITS-1:0]   thread_t;
    typedef logic [REG_BITS-1:0]      reg_idx_t;
    typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

    // Each thread owns a bank of 8 registers: the thread number is the upper address field.
    function automatic reg_addr_t rf_addr(input thread_t thread, input reg_idx_t idx);
        return {thread, idx};
    endfunction

endpackage

// File: rtl/bcpu_operand_mux.sv
// Operand select: immediate, then register-0-as-zero, then write-back bypass, then register file.
module bcpu_operand_mux
    import bcpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_b_imm,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  reg_idx_t              i_reg,
    input  reg_addr_t             i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_wr_en,
    input  reg_addr_t             i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Priority chain; register 0 beats bypass so writes to r0 can never leak through.
    always_comb begin
        o_data = i_rd_data;
        if (i_b_imm) begin
            o_data = i_imm;
        end else if (i_reg == '0) begin
            o_data = '0;
        end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            // The register file updates on this same edge, so its read data is still stale.
            o_data = i_wr_data;
        end
    end

endmodule

// File: rtl/bcpu_operand_fetch.sv
// BCPU16 operand-fetch stage: barrel thread counter, register file addressing and operand registers.
module bcpu_operand_fetch
    import bcpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      CE,
    output logic [1:0]                THREAD,
    input  logic                      IN_VALID,
    input  logic [2:0]                IN_RA,
    input  logic [2:0]                IN_RB,
    input  logic [2:0]                IN_RD,
    input  logic                      IN_B_IMM,
    input  logic [DATA_WIDTH-1:0]     IN_IMM,
    input  logic [CTRL_WIDTH-1:0]     IN_CTRL,
    output logic [REG_ADDR_WIDTH-1:0] RD_REG_ADDR_A,
    output logic [REG_ADDR_WIDTH-1:0] RD_REG_ADDR_B,
    input  logic [DATA_WIDTH-1:0]     RD_REG_DATA_A,
    input  logic [DATA_WIDTH-1:0]     RD_REG_DATA_B,
    input  logic                      REG_WR_EN,
    input  logic [REG_ADDR_WIDTH-1:0] WR_REG_ADDR,
    input  logic [DATA_WIDTH-1:0]     WR_REG_DATA,
    output logic                      OUT_VALID,
    output logic [1:0]                OUT_THREAD,
    output logic [2:0]                OUT_RD,
    output logic [CTRL_WIDTH-1:0]     OUT_CTRL,
    output logic [DATA_WIDTH-1:0]     OUT_A,
    output logic [DATA_WIDTH-1:0]     OUT_B
);

    if (THREAD_BITS + REG_BITS != REG_ADDR_WIDTH) begin : g_bad_addr_width
        $error("REG_ADDR_WIDTH must equal THREAD_BITS + REG_BITS");
    end

    thread_t                 r_thread;
    logic                    r_out_valid;
    thread_t                 r_out_thread;
    reg_idx_t                r_out_rd;
    logic [CTRL_WIDTH-1:0]   r_out_ctrl;
    logic [DATA_WIDTH-1:0]   r_out_a;
    logic [DATA_WIDTH-1:0]   r_out_b;

    reg_addr_t               w_addr_a;
    reg_addr_t               w_addr_b;
    logic [DATA_WIDTH-1:0]   w_opnd_a;
    logic [DATA_WIDTH-1:0]   w_opnd_b;

    // Read addresses are formed every cycle, valid instruction or not.
    assign w_addr_a      = rf_addr(r_thread, IN_RA);
    assign w_addr_b      = rf_addr(r_thread, IN_RB);
    assign RD_REG_ADDR_A = w_addr_a;
    assign RD_REG_ADDR_B = w_addr_b;

    bcpu_operand_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux_a (
        .i_b_imm   (1'b0),
        .i_imm     ({DATA_WIDTH{1'b0}}),
        .i_reg     (IN_RA),
        .i_rd_addr (w_addr_a),
        .i_rd_data (RD_REG_DATA_A),
        .i_wr_en   (REG_WR_EN),
        .i_wr_addr (WR_REG_ADDR),
        .i_wr_data (WR_REG_DATA),
        .o_data    (w_opnd_a)
    );

    bcpu_operand_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux_b (
        .i_b_imm   (IN_B_IMM),
        .i_imm     (IN_IMM),
        .i_reg     (IN_RB),
        .i_rd_addr (w_addr_b),
        .i_rd_data (RD_REG_DATA_B),
        .i_wr_en   (REG_WR_EN),
        .i_wr_addr (WR_REG_ADDR),
        .i_wr_data (WR_REG_DATA),
        .o_data    (w_opnd_b)
    );

    // Barrel counter and operand registers advance together on CE and hold through a stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_thread     <= '0;
            r_out_valid  <= 1'b0;
            r_out_thread <= '0;
            r_out_rd     <= '0;
            r_out_ctrl   <= '0;
            r_out_a      <= '0;
            r_out_b      <= '0;
        end else if (CE) begin
            r_thread     <= r_thread + 1'b1;
            r_out_valid  <= IN_VALID;
            r_out_thread <= r_thread;
            r_out_rd     <= IN_RD;
            r_out_ctrl   <= IN_CTRL;
            r_out_a      <= w_opnd_a;
            r_out_b      <= w_opnd_b;
        end
    end

    assign THREAD     = r_thread;
    assign OUT_VALID  = r_out_valid;
    assign OUT_THREAD = r_out_thread;
    assign OUT_RD     = r_out_rd;
    assign OUT_CTRL   = r_out_ctrl;
    assign OUT_A      = r_out_a;
    assign OUT_B      = r_out_b;

endmodule

// File: tb/tb_bcpu_operand_fetch.sv
// Directed bench for bcpu_operand_fetch: vector table plus stall and async-reset sequences.
module tb_bcpu_operand_fetch;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          CLK;
    logic          RST_N;
    logic          CE;
    logic [1:0]    THREAD;
    logic          IN_VALID;
    logic [2:0]    IN_RA, IN_RB, IN_RD;
    logic          IN_B_IMM;
    logic [DW-1:0] IN_IMM;
    logic [CW-1:0] IN_CTRL;
    logic [AW-1:0] RD_REG_ADDR_A, RD_REG_ADDR_B;
    logic [DW-1:0] RD_REG_DATA_A, RD_REG_DATA_B;
    logic          REG_WR_EN;
    logic [AW-1:0] WR_REG_ADDR;
    logic [DW-1:0] WR_REG_DATA;
    logic          OUT_VALID;
    logic [1:0]    OUT_THREAD;
    logic [2:0]    OUT_RD;
    logic [CW-1:0] OUT_CTRL;
    logic [DW-1:0] OUT_A, OUT_B;

    bcpu_operand_fetch #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .CTRL_WIDTH     (CW)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .CE            (CE),
        .THREAD        (THREAD),
        .IN_VALID      (IN_VALID),
        .IN_RA         (IN_RA),
        .IN_RB         (IN_RB),
        .IN_RD         (IN_RD),
        .IN_B_IMM      (IN_B_IMM),
        .IN_IMM        (IN_IMM),
        .IN_CTRL       (IN_CTRL),
        .RD_REG_ADDR_A (RD_REG_ADDR_A),
        .RD_REG_ADDR_B (RD_REG_ADDR_B),
        .RD_REG_DATA_A (RD_REG_DATA_A),
        .RD_REG_DATA_B (RD_REG_DATA_B),
        .REG_WR_EN     (REG_WR_EN),
        .WR_REG_ADDR   (WR_REG_ADDR),
        .WR_REG_DATA   (WR_REG_DATA),
        .OUT_VALID     (OUT_VALID),
        .OUT_THREAD    (OUT_THREAD),
        .OUT_RD        (OUT_RD),
        .OUT_CTRL      (OUT_CTRL),
        .OUT_A         (OUT_A),
        .OUT_B         (OUT_B)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic          valid;
        logic [2:0]    ra, rb, rd;
        logic          bimm;
        logic [DW-1:0] imm;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] da, db;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          chk_data;
        logic [AW-1:0] exp_addr_a, exp_addr_b;
        logic [DW-1:0] exp_a, exp_b;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic valid, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
        input logic bimm, input logic [DW-1:0] imm, input logic [CW-1:0] ctrl,
        input logic [DW-1:0] da, input logic [DW-1:0] db,
        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic chk_data, input logic [AW-1:0] ea_addr, input logic [AW-1:0] eb_addr,
        input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        vec_t v;
        v.valid = valid; v.ra = ra; v.rb = rb; v.rd = rd;
        v.bimm = bimm; v.imm = imm; v.ctrl = ctrl;
        v.da = da; v.db = db; v.we = we; v.wa = wa; v.wd = wd;
        v.chk_data = chk_data; v.exp_addr_a = ea_addr; v.exp_addr_b = eb_addr;
        v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        IN_VALID      = v.valid;
        IN_RA         = v.ra;
        IN_RB         = v.rb;
        IN_RD         = v.rd;
        IN_B_IMM      = v.bimm;
        IN_IMM        = v.imm;
        IN_CTRL       = v.ctrl;
        RD_REG_DATA_A = v.da;
        RD_REG_DATA_B = v.db;
        REG_WR_EN     = v.we;
        WR_REG_ADDR   = v.wa;
        WR_REG_DATA   = v.wd;
    endtask

    logic [1:0]    held_thread;
    logic [DW-1:0] held_a, held_b;
    logic [2:0]    held_rd;
    logic [CW-1:0] held_ctrl;

    initial begin
        // Vector i runs in thread i % 4 (counter is back at 0 after the 8 idle edges).
        //           vld ra  rb  rd  bimm imm      ctrl   da       db       we wa     wd       chk a_addr b_addr exp_a    exp_b
        vecs[0] = mk(1, 3'd1, 3'd2, 3'd4, 0, 16'h0000, 8'h5A, 16'h1111, 16'h2222, 0, 5'h00, 16'h0000, 1, 5'h01, 5'h02, 16'h1111, 16'h2222);
        vecs[1] = mk(1, 3'd2, 3'd3, 3'd1, 0, 16'h0000, 8'h11, 16'h0C0C, 16'h0000, 1, 5'h0B, 16'hA5A5, 1, 5'h0A, 5'h0B, 16'h0C0C, 16'hA5A5);
        vecs[2] = mk(1, 3'd3, 3'd5, 3'd6, 0, 16'h0000, 8'h22, 16'h1234, 16'hBEEF, 0, 5'h00, 16'h0000, 1, 5'h13, 5'h15, 16'h1234, 16'hBEEF);
        vecs[3] = mk(1, 3'd0, 3'd7, 3'd2, 0, 16'h0000, 8'h33, 16'hFFFF, 16'h7777, 0, 5'h00, 16'h0000, 1, 5'h18, 5'h1F, 16'h0000, 16'h7777);
        vecs[4] = mk(1, 3'd6, 3'd6, 3'd3, 0, 16'h0000, 8'h44, 16'h0001, 16'h0002, 1, 5'h06, 16'h5555, 1, 5'h06, 5'h06, 16'h5555, 16'h5555);
        vecs[5] = mk(1, 3'd3, 3'd3, 3'd5, 1, 16'h0007, 8'h55, 16'h0000, 16'h0000, 1, 5'h0B, 16'hA5A5, 1, 5'h0B, 5'h0B, 16'hA5A5, 16'h0007);
        vecs[6] = mk(1, 3'd0, 3'd0, 3'd7, 0, 16'h0000, 8'h66, 16'h9999, 16'h8888, 1, 5'h10, 16'hDEAD, 1, 5'h10, 5'h10, 16'h0000, 16'h0000);
        vecs[7] = mk(1, 3'd1, 3'd5, 3'd0, 0, 16'h0000, 8'h77, 16'h8000, 16'h4321, 1, 5'h05, 16'hCAFE, 1, 5'h19, 5'h1D, 16'h8000, 16'h4321);
        vecs[8] = mk(0, 3'd2, 3'd4, 3'd1, 0, 16'h0000, 8'h88, 16'h0F0F, 16'hF0F0, 0, 5'h00, 16'h0000, 0, 5'h02, 5'h04, 16'h0000, 16'h0000);
        vecs[9] = mk(1, 3'd1, 3'd4, 3'd3, 0, 16'h0000, 8'h99, 16'h3333, 16'h4444, 0, 5'h09, 16'hEEEE, 1, 5'h09, 5'h0C, 16'h3333, 16'h4444);

        RST_N = 1'b0;
        CE    = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("reset_thread",     32'(THREAD),     32'h0);
        chk("reset_out_valid",  32'(OUT_VALID),  32'h0);
        chk("reset_out_thread", 32'(OUT_THREAD), 32'h0);
        chk("reset_out_rd",     32'(OUT_RD),     32'h0);
        chk("reset_out_ctrl",   32'(OUT_CTRL),   32'h0);
        chk("reset_out_a",      32'(OUT_A),      32'h0);
        chk("reset_out_b",      32'(OUT_B),      32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Idle edges: counter walks 0..3 twice, nothing becomes valid.
        CE = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("idle_thread_%0d", k), 32'(THREAD), 32'(k % 4));
            @(posedge CLK);
            #1;
            chk($sformatf("idle_valid_%0d", k), 32'(OUT_VALID), 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_addr_a", i), 32'(RD_REG_ADDR_A), 32'(vecs[i].exp_addr_a));
            chk($sformatf("v%0d_addr_b", i), 32'(RD_REG_ADDR_B), 32'(vecs[i].exp_addr_b));
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_valid", i),      32'(OUT_VALID),  32'(vecs[i].valid));
            chk($sformatf("v%0d_out_thread", i), 32'(OUT_THREAD), 32'(i % 4));
            chk($sformatf("v%0d_thread", i),     32'(THREAD),     32'((i + 1) % 4));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_out_a", i),    32'(OUT_A),    32'(vecs[i].exp_a));
                chk($sformatf("v%0d_out_b", i),    32'(OUT_B),    32'(vecs[i].exp_b));
                chk($sformatf("v%0d_out_rd", i),   32'(OUT_RD),   32'(vecs[i].rd));
                chk($sformatf("v%0d_out_ctrl", i), 32'(OUT_CTRL), 32'(vecs[i].ctrl));
            end
        end

        // Stall: last vector's results and thread 2 must hold while everything moves.
        held_thread = 2'd2;
        held_a      = vecs[NV-1].exp_a;
        held_b      = vecs[NV-1].exp_b;
        held_rd     = vecs[NV-1].rd;
        held_ctrl   = vecs[NV-1].ctrl;
        CE = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive(mk(1, 3'(s + 1), 3'(s + 2), 3'(7 - s), 0, 16'h0000, 8'(8'hE0 + s),
                     16'(16'h7000 + s), 16'(16'h6000 + s), 1, 5'(5'h11 + s), 16'hBAD0,
                     0, 0, 0, 0, 0));
            @(posedge CLK);
            #1;
            chk($sformatf("stall%0d_thread", s),     32'(THREAD),     32'(held_thread));
            chk($sformatf("stall%0d_valid", s),      32'(OUT_VALID),  32'h1);
            chk($sformatf("stall%0d_out_thread", s), 32'(OUT_THREAD), 32'h1);
            chk($sformatf("stall%0d_out_a", s),      32'(OUT_A),      32'(held_a));
            chk($sformatf("stall%0d_out_b", s),      32'(OUT_B),      32'(held_b));
            chk($sformatf("stall%0d_out_rd", s),     32'(OUT_RD),     32'(held_rd));
            chk($sformatf("stall%0d_out_ctrl", s),   32'(OUT_CTRL),   32'(held_ctrl));
        end

        // Resume: thread 2 instruction captured, counter moves on to 3.
        CE = 1'b1;
        drive(mk(1, 3'd4, 3'd2, 3'd5, 0, 16'h0000, 8'hC3, 16'h0ABC, 16'h0DEF, 0, 5'h00, 16'h0000,
                 1, 5'h14, 5'h12, 16'h0ABC, 16'h0DEF));
        #1;
        chk("resume_addr_a", 32'(RD_REG_ADDR_A), 32'h14);
        @(posedge CLK);
        #1;
        chk("resume_thread",     32'(THREAD),     32'h3);
        chk("resume_out_thread", 32'(OUT_THREAD), 32'h2);
        chk("resume_out_a",      32'(OUT_A),      32'h0ABC);
        chk("resume_out_b",      32'(OUT_B),      32'h0DEF);
        chk("resume_valid",      32'(OUT_VALID),  32'h1);

        // Asynchronous reset mid-cycle, well before the next rising edge.
        #2;
        RST_N = 1'b0;
        #1;
        chk("areset_valid",  32'(OUT_VALID), 32'h0);
        chk("areset_out_a",  32'(OUT_A),     32'h0);
        chk("areset_out_b",  32'(OUT_B),     32'h0);
        chk("areset_thread", 32'(THREAD),    32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        // First CE edge after reset captures a thread 0 instruction.
        drive(mk(1, 3'd2, 3'd3, 3'd4, 0, 16'h0000, 8'h3C, 16'h2468, 16'h1357, 0, 5'h00, 16'h0000,
                 1, 5'h02, 5'h03, 16'h2468, 16'h1357));
        #1;
        chk("post_reset_addr_b", 32'(RD_REG_ADDR_B), 32'h03);
        @(posedge CLK);
        #1;
        chk("post_reset_out_thread", 32'(OUT_THREAD), 32'h0);
        chk("post_reset_out_a",      32'(OUT_A),      32'h2468);
        chk("post_reset_thread",     32'(THREAD),     32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcpu_operand_fetch.md
# bcpu_operand_fetch

Operand-fetch stage of the BCPU16 barrel pipeline, between instruction decode and execute. It owns the 4-thread barrel counter, forms the two asynchronous read addresses for the 32-entry register file, and registers the operands. It applies register-0-reads-zero, same-cycle write-back bypass and the immediate select. The execute stage sees the operands one cycle after decode presents the instruction.

## Interface
- DATA_WIDTH, 16: operand/register width (16, 17, 18).
- REG_ADDR_WIDTH, 5: register file address width; upper 2 bits thread, lower 3 bits register.
- CTRL_WIDTH, 8: opaque decoded control bundle, passed through unchanged.

- CLK  in  1  clock; everything is sampled on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CE  in  1  stage advance enable; 0 = stall.
- THREAD  out  2  current barrel thread; decode must present this thread's instruction.
- IN_VALID  in  1  decoded instruction present.
- IN_RA, IN_RB, IN_RD  in  3 each  source A, source B, destination register numbers.
- IN_B_IMM  in  1  operand B from IN_IMM instead of the register file.
- IN_IMM  in  DATA_WIDTH  immediate, already extended by decode.
- IN_CTRL  in  CTRL_WIDTH  control bundle.
- RD_REG_ADDR_A, RD_REG_ADDR_B  out  REG_ADDR_WIDTH  register file read addresses.
- RD_REG_DATA_A, RD_REG_DATA_B  in  DATA_WIDTH  register file asynchronous read data.
- REG_WR_EN, WR_REG_ADDR, WR_REG_DATA  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  snoop of the register file write port.
- OUT_VALID  out  1  operands valid for execute.
- OUT_THREAD  out  2; OUT_RD  out  3; OUT_CTRL  out  CTRL_WIDTH  pipelined copies of the instruction fields.
- OUT_A, OUT_B  out  DATA_WIDTH  registered operands.

## Operation
- THREAD counter: 2-bit, increments by 1 on each edge with CE=1; wraps 3 -> 0 with no special case; holds while CE=0.
- Read addresses (combinational): RD_REG_ADDR_A = {THREAD, IN_RA}; RD_REG_ADDR_B = {THREAD, IN_RB}. They are driven even when IN_VALID=0.
- Operand A selection, in priority order:
  1. IN_RA == 0 -> 0.
  2. REG_WR_EN and WR_REG_ADDR == RD_REG_ADDR_A -> WR_REG_DATA (bypass; the register file updates on the same edge).
  3. Otherwise -> RD_REG_DATA_A.
- Operand B selection, in priority order:
  1. IN_B_IMM -> IN_IMM (overrides everything).
  2. Otherwise the same rules as operand A, using IN_RB and port B.
- Capture: on an edge with CE=1, OUT_VALID <= IN_VALID and all OUT_* are loaded.
  - If IN_VALID=0, OUT_A, OUT_B and the other data outputs still load; their values are don't-care.
- Stall: CE=0 holds every output and THREAD.
  - Writes during a stall do not refresh the held OUT_A/OUT_B.
  - The 4-thread interleave guarantees a thread's write-back completes before that thread's next read.
- Writes to register 0 are not blocked here; the read-as-zero rule masks them.

## Timing
- Reset (RST_N=0, asynchronous): THREAD=0, OUT_VALID=0, OUT_THREAD=0, OUT_RD=0, OUT_CTRL=0, OUT_A=0, OUT_B=0.
- Deassertion of RST_N is synchronised externally. The first CE edge after reset captures the thread 0 instruction.
- Latency: instruction presented in cycle n with CE=1 -> OUT_* valid in cycle n+1.
- Throughput: 1 instruction per CE cycle; consecutive instructions belong to threads 0, 1, 2, 3, 0, ...
- Combinational path: IN_RA/IN_RB and THREAD -> RD_REG_ADDR_*; the register file read path -> OUT_* D inputs.
- Simultaneous events:
  - Bypass and register 0 both match -> register 0 wins (value 0).
  - Both ports match the write address -> both are bypassed.
- Reset mid-stall or mid-stream: the in-flight instruction is discarded (OUT_VALID=0) and THREAD restarts at 0.

## Structure
- Shared package bcpu_pkg holds:
  - THREAD_BITS=2 and REG_BITS=3 (with THREAD_BITS+REG_BITS == REG_ADDR_WIDTH);
  - typedefs thread_t, reg_idx_t, reg_addr_t;
  - the register file address concatenation helper.
- One sub-module: bcpu_operand_mux, the purely combinational zero/bypass/register/immediate select. It is instantiated twice; B uses the immediate path, A ties it off.
- Pipeline registers and the THREAD counter live in the top module.

## Test plan
- Reset, then 8 edges with CE=1 -> THREAD sequence 0,1,2,3,0,1,2,3 and OUT_VALID=0 throughout while IN_VALID=0.
- THREAD=2, IN_RA=3, IN_RB=5, register file model returns 0x1234/0xBEEF -> RD_REG_ADDR_A=0x13, RD_REG_ADDR_B=0x15; next cycle OUT_A=0x1234, OUT_B=0xBEEF, OUT_THREAD=2, OUT_VALID=1.
- IN_RA=0 with the register file model returning 0xFFFF at address {THREAD,0} -> OUT_A=0x0000.
- Bypass: REG_WR_EN=1, WR_REG_ADDR=0x0B, WR_REG_DATA=0xA5A5, THREAD=1, IN_RB=3, register file returns 0x0000 -> OUT_B=0xA5A5. Repeat with IN_B_IMM=1, IN_IMM=0x0007 -> OUT_B=0x0007.
- Stall: CE=0 for 3 cycles while inputs and register file data change -> THREAD and all OUT_* unchanged. CE=1 resumes from the held THREAD+1.
- Assert RST_N=0 mid-cycle with OUT_VALID=1 -> OUT_VALID, OUT_A and THREAD go to 0 immediately, without waiting for CLK.
